// File: rtl/shf_arbiter.sv
// Round-robin arbiter sharing one combinational 16-bit shifter
// between the SHF execute path and the LSHF address path.
module shf_arbiter #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic             req0_a,
   input  logic             req0_d,
   input  logic [AMT_W-1:0] req0_amt,
   input  logic [WIDTH-1:0] req0_in,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic             req1_a,
   input  logic             req1_d,
   input  logic [AMT_W-1:0] req1_amt,
   input  logic [WIDTH-1:0] req1_in,
   output logic             sh_a,
   output logic             sh_d,
   output logic [AMT_W-1:0] sh_amt,
   output logic [WIDTH-1:0] sh_in,
   input  logic [WIDTH-1:0] sh_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   typedef struct packed {
      logic             a;
      logic             d;
      logic [AMT_W-1:0] amt;
      logic [WIDTH-1:0] in;
   } op_t;

   state_t           state_q, state_d;
   op_t              op_q, op_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             g0, g1;

   // On a tie, the requester not served last wins.
   assign g0 = req0_valid & (~req1_valid | last_q);
   assign g1 = req1_valid & (~req0_valid | ~last_q);

   assign req0_ready = (state_q == IDLE) & g0 & ~rst;
   assign req1_ready = (state_q == IDLE) & g1 & ~rst;

   assign sh_a      = op_q.a;
   assign sh_d      = op_q.d;
   assign sh_amt    = op_q.amt;
   assign sh_in     = op_q.in;
   assign rsp_valid = (state_q == RESP) & ~rst;
   assign rsp_id    = owner_q;
   assign rsp_data  = data_q;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      owner_d = owner_q;
      last_d  = last_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            if (req0_ready) begin
               op_d    = '{req0_a, req0_d, req0_amt, req0_in};
               owner_d = 1'b0;
               last_d  = 1'b0;
               state_d = EXEC;
            end else if (req1_ready) begin
               op_d    = '{req1_a, req1_d, req1_amt, req1_in};
               owner_d = 1'b1;
               last_d  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            data_d  = sh_out;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_shf_arbiter.sv
// Directed self-checking bench for shf_arbiter with a
// behavioural LC-3b shifter on the sh_* pins.
module tb_shf_arbiter;

   localparam int WIDTH = 16;
   localparam int AMT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req0_ready, req0_a, req0_d;
   logic [AMT_W-1:0] req0_amt;
   logic [WIDTH-1:0] req0_in;
   logic             req1_valid, req1_ready, req1_a, req1_d;
   logic [AMT_W-1:0] req1_amt;
   logic [WIDTH-1:0] req1_in;
   logic             sh_a, sh_d;
   logic [AMT_W-1:0] sh_amt;
   logic [WIDTH-1:0] sh_in, sh_out;
   logic             rsp_valid, rsp_ready, rsp_id;
   logic [WIDTH-1:0] rsp_data;

   int checks   = 0;
   int failures = 0;

   shf_arbiter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_d     (req0_d),
      .req0_amt   (req0_amt),
      .req0_in    (req0_in),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_d     (req1_d),
      .req1_amt   (req1_amt),
      .req1_in    (req1_in),
      .sh_a       (sh_a),
      .sh_d       (sh_d),
      .sh_amt     (sh_amt),
      .sh_in      (sh_in),
      .sh_out     (sh_out),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data)
   );

   always #5 clk = ~clk;

   always_comb begin
      if (!sh_d)
         sh_out = sh_in << sh_amt;
      else if (sh_a)
         sh_out = WIDTH'($signed(sh_in) >>> sh_amt);
      else
         sh_out = sh_in >> sh_amt;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set0(input logic a, input logic d,
                       input logic [3:0] amt,
                       input logic [15:0] v);
      req0_a = a; req0_d = d; req0_amt = amt; req0_in = v;
   endtask

   task automatic set1(input logic a, input logic d,
                       input logic [3:0] amt,
                       input logic [15:0] v);
      req1_a = a; req1_d = d; req1_amt = amt; req1_in = v;
   endtask

   // One solo req1 operation with rsp_ready held high.
   task automatic op1(input string tag,
                      input logic [15:0] exp);
      req1_valid = 1'b1;
      #1;
      chk({tag, "_rdy1"}, req1_ready, 1);
      chk({tag, "_rdy0"}, req0_ready, 0);
      tick;
      req1_valid = 1'b0;
      tick;
      chk({tag, "_vld"}, rsp_valid, 1);
      chk({tag, "_data"}, rsp_data, exp);
      chk({tag, "_id"}, rsp_id, 1);
      tick;
   endtask

   initial begin
      rst = 1'b1;
      rsp_ready = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      set0(0, 0, 0, 0);
      set1(0, 0, 0, 0);
      tick;
      tick;
      // reset state, ready held low while in reset
      req0_valid = 1'b1;
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_sh", {sh_a, sh_d, sh_amt, sh_in}, 0);
      chk("rst_rdy0", req0_ready, 0);
      req0_valid = 1'b0;
      tick;

      // single left shift on req0
      rst = 1'b0;
      rsp_ready = 1'b1;
      set0(0, 0, 2, 16'h002B);
      req0_valid = 1'b1;
      #1;
      chk("l_rdy0", req0_ready, 1);
      chk("l_rdy1", req1_ready, 0);
      tick;
      req0_valid = 1'b0;
      #1;
      chk("l_exec_rdy0", req0_ready, 0);
      chk("l_exec_vld", rsp_valid, 0);
      chk("l_sh_in", sh_in, 16'h002B);
      chk("l_sh_amt", sh_amt, 2);
      tick;
      chk("l_vld", rsp_valid, 1);
      chk("l_data", rsp_data, 16'h00AC);
      chk("l_id", rsp_id, 0);
      tick;
      chk("l_retired", rsp_valid, 0);

      // right logical, arithmetic, zero amount on req1
      set1(0, 1, 3, 16'h8000);
      op1("rlog", 16'h1000);
      set1(1, 1, 3, 16'h8000);
      op1("rari", 16'hF000);
      set1(1, 1, 0, 16'h8000);
      op1("ramt0", 16'h8000);

      // contention straight after reset
      rst = 1'b1;
      tick;
      rst = 1'b0;
      set0(0, 0, 4, 16'h0001);
      set1(0, 1, 4, 16'h00F0);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("ct%0d_rdy0", i), req0_ready,
             (i == 1) ? 0 : 1);
         chk($sformatf("ct%0d_rdy1", i), req1_ready,
             (i == 1) ? 1 : 0);
         tick;
         chk($sformatf("ct%0d_exec_rdy", i),
             {req0_ready, req1_ready}, 0);
         tick;
         chk($sformatf("ct%0d_id", i), rsp_id,
             (i == 1) ? 1 : 0);
         chk($sformatf("ct%0d_data", i), rsp_data,
             (i == 1) ? 16'h000F : 16'h0010);
         tick;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // backpressure, req1 waiting behind the stalled result
      rsp_ready = 1'b0;
      set0(1, 1, 4, 16'h1234);
      set1(0, 0, 8, 16'h00FF);
      req0_valid = 1'b1;
      #1;
      chk("bp_rdy0", req0_ready, 1);
      tick;
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      tick;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp%0d_vld", i), rsp_valid, 1);
         chk($sformatf("bp%0d_data", i), rsp_data, 16'h0123);
         chk($sformatf("bp%0d_id", i), rsp_id, 0);
         chk($sformatf("bp%0d_rdy", i),
             {req0_ready, req1_ready}, 0);
         tick;
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_retire_rdy1", req1_ready, 0);
      tick;
      chk("bp_after_vld", rsp_valid, 0);
      chk("bp_after_rdy1", req1_ready, 1);
      tick;
      req1_valid = 1'b0;
      tick;
      chk("bp_next_data", rsp_data, 16'hFF00);
      chk("bp_next_id", rsp_id, 1);
      tick;

      // reset in EXEC
      set0(0, 0, 1, 16'h0003);
      req0_valid = 1'b1;
      tick;
      req0_valid = 1'b0;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      #1;
      chk("rx_vld", rsp_valid, 0);
      chk("rx_data", rsp_data, 0);
      chk("rx_sh", {sh_a, sh_d, sh_amt, sh_in}, 0);
      tick;
      chk("rx_no_rsp", rsp_valid, 0);

      // reset in RESP, then a tie must go to req0
      rsp_ready = 1'b0;
      req0_valid = 1'b1;
      tick;
      req0_valid = 1'b0;
      tick;
      chk("rr_pre_vld", rsp_valid, 1);
      chk("rr_pre_data", rsp_data, 16'h0006);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      #1;
      chk("rr_vld", rsp_valid, 0);
      chk("rr_data", rsp_data, 0);
      chk("rr_sh", {sh_a, sh_d, sh_amt, sh_in}, 0);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("rr_tie_rdy0", req0_ready, 1);
      chk("rr_tie_rdy1", req1_ready, 0);

      // withdrawn req1 pulse while in RESP
      tick;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick;
      chk("wd_vld", rsp_valid, 1);
      req1_valid = 1'b1;
      #1;
      chk("wd_rdy1", req1_ready, 0);
      tick;
      req1_valid = 1'b0;
      rsp_ready = 1'b1;
      tick;
      chk("wd_idle", rsp_valid, 0);
      tick;
      chk("wd_no_rsp", rsp_valid, 0);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("wd_tie_rdy1", req1_ready, 1);
      chk("wd_tie_rdy0", req0_ready, 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick;

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
